// File: rtl/clock_gen_pkg.sv
// Shared division ratios and counter step sizes for clock_gen.
package clock_gen_pkg;

  localparam int unsigned DIV28_HALF  = 14;
  localparam int unsigned DIV5_PERIOD = 5;
  localparam int unsigned DIV5_HIGH   = 2;
  localparam int unsigned TC_INC      = 2;
  localparam int unsigned TC_DEC      = 5;
  localparam int unsigned TC_WIDTH    = 8;

endpackage

// File: rtl/clock_gen_mod_counter.sv
// Generic modulo-N up-counter with a combinational pulse on the terminal count.
module mod_counter #(
  parameter int unsigned N = 14,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = (count == LAST);

  // Count 0..N-1, returning to 0 after the terminal value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_gen.sv
// Divided square waves plus a +2/-5 demonstration counter, all registered in clk_in.
module clock_gen
  import clock_gen_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst,
  output logic                clk_div_2,
  output logic                clk_div_4,
  output logic                clk_div_8,
  output logic                clk_div_16,
  output logic                clk_div_28,
  output logic                clk_div_5,
  output logic [TC_WIDTH-1:0] toggle_counter
);

  localparam logic [2:0] DIV5_LAST   = 3'(DIV5_PERIOD - 1);
  localparam logic [2:0] DIV5_RISE   = 3'(DIV5_PERIOD - DIV5_HIGH);
  localparam logic [TC_WIDTH-1:0] TC_UP   = TC_WIDTH'(TC_INC);
  localparam logic [TC_WIDTH-1:0] TC_DOWN = TC_WIDTH'(TC_DEC);

  logic [3:0] cnt16;
  logic [3:0] cnt14;
  logic       wrap14;
  logic [2:0] cnt5;
  logic       strobe4;

  assign clk_div_2  = cnt16[0];
  assign clk_div_4  = cnt16[1];
  assign clk_div_8  = cnt16[2];
  assign clk_div_16 = cnt16[3];
  assign strobe4    = (cnt16[1:0] == 2'd3);

  // Free-running phase reference for the power-of-two dividers.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt16 <= '0;
    end else begin
      cnt16 <= cnt16 + 1'b1;
    end
  end

  mod_counter #(
    .N (DIV28_HALF),
    .W (4)
  ) u_cnt14 (
    .clk   (clk_in),
    .rst   (rst),
    .count (cnt14),
    .wrap  (wrap14)
  );

  // Half-period toggle for the divide-by-28 wave.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      clk_div_28 <= 1'b0;
    end else if (wrap14) begin
      clk_div_28 <= ~clk_div_28;
    end
  end

  // Divide-by-5 phase counter; output is decoded from the pre-update phase.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt5      <= '0;
      clk_div_5 <= 1'b0;
    end else begin
      cnt5      <= (cnt5 == DIV5_LAST) ? '0 : cnt5 + 1'b1;
      clk_div_5 <= (cnt5 >= DIV5_RISE);
    end
  end

  // Step +2 normally, -5 on the divide-by-4 strobe, wrapping modulo 256.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      toggle_counter <= '0;
    end else if (strobe4) begin
      toggle_counter <= toggle_counter - TC_DOWN;
    end else begin
      toggle_counter <= toggle_counter + TC_UP;
    end
  end

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: edge-count model plus literal spot checks.
module tb_clock_gen;

  logic       clk_in;
  logic       rst;
  logic       clk_div_2, clk_div_4, clk_div_8, clk_div_16, clk_div_28, clk_div_5;
  logic [7:0] toggle_counter;

  int compared   = 0;
  int mismatched = 0;

  clock_gen dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .clk_div_2      (clk_div_2),
    .clk_div_4      (clk_div_4),
    .clk_div_8      (clk_div_8),
    .clk_div_16     (clk_div_16),
    .clk_div_28     (clk_div_28),
    .clk_div_5      (clk_div_5),
    .toggle_counter (toggle_counter)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: outputs depend only on k, the number of edges since reset released.
  function automatic int m_sq(input int k, input int p);
    return ((k % p) >= (p / 2)) ? 1 : 0;
  endfunction

  function automatic int m_div5(input int k);
    if (k == 0) return 0;
    return (((k - 1) % 5) >= 3) ? 1 : 0;
  endfunction

  function automatic int m_tc(input int k);
    return (2 * k - 7 * (k / 4)) % 256;
  endfunction

  int  k    = 0;
  bit  seen = 0;

  // Per-cycle compare of every output against the model.
  always @(posedge clk_in) begin
    logic r;
    r = rst;
    #1;
    if (!r) begin
      k    = 0;
      seen = 1;
    end else if (seen) begin
      k++;
    end
    if (seen) begin
      check("m_div2",  int'(clk_div_2),  m_sq(k, 2));
      check("m_div4",  int'(clk_div_4),  m_sq(k, 4));
      check("m_div8",  int'(clk_div_8),  m_sq(k, 8));
      check("m_div16", int'(clk_div_16), m_sq(k, 16));
      check("m_div28", int'(clk_div_28), m_sq(k, 28));
      check("m_div5",  int'(clk_div_5),  m_div5(k));
      check("m_tc",    int'(toggle_counter), m_tc(k));
    end
  end

  // Hand-computed expectations along the edges after a release.
  task automatic run_edges(input int n);
    int tc_seq[8]  = '{2, 4, 6, 1, 3, 5, 7, 2};
    int d5_seq[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    for (int e = 1; e <= n; e++) begin
      @(posedge clk_in);
      #1;
      if (e <= 8)  check("lit_tc", int'(toggle_counter), tc_seq[e-1]);
      if (e <= 10) check("lit_div5", int'(clk_div_5), d5_seq[e-1]);
      if (e == 1)  check("lit_div2_rise", int'(clk_div_2), 1);
      if (e == 2)  check("lit_div4_rise", int'(clk_div_4), 1);
      if (e == 3)  check("lit_div8_low", int'(clk_div_8), 0);
      if (e == 4)  check("lit_div8_rise", int'(clk_div_8), 1);
      if (e == 7)  check("lit_div16_low", int'(clk_div_16), 0);
      if (e == 8)  check("lit_div16_rise", int'(clk_div_16), 1);
      if (e == 13) check("lit_div28_pre", int'(clk_div_28), 0);
      if (e == 14) check("lit_div28_rise", int'(clk_div_28), 1);
      if (e == 27) check("lit_div28_hold", int'(clk_div_28), 1);
      if (e == 28) check("lit_div28_fall", int'(clk_div_28), 0);
      if (e == 42) check("lit_div28_rise2", int'(clk_div_28), 1);
      if (e == 56) check("lit_div28_fall2", int'(clk_div_28), 0);
      if (e == 1024) check("lit_tc_1024", int'(toggle_counter), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, int'({clk_div_2, clk_div_4, clk_div_8, clk_div_16,
                                 clk_div_28, clk_div_5}), 0);
    check({tag, "_tc"}, int'(toggle_counter), 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      check_all_zero("lit_reset_hold");
    end

    @(negedge clk_in);
    rst = 1'b1;
    run_edges(37);

    // One-cycle reset in mid-run, then the waveforms must restart from phase 0.
    @(negedge clk_in);
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    check_all_zero("lit_midrun_reset");
    @(negedge clk_in);
    rst = 1'b1;
    run_edges(1024);

    repeat (2) @(posedge clk_in);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
